train_step_mul_pipe_sat: RTL

//  Parametrised, pipelined, multi-lane signed multiplier for the train_step datapath.
//  It is the successor of the fixed-width combinational multiplier cores.
//  Per lane it computes din0*din1, then an arithmetic right shift by SHIFT with round-half-up.
//  The result is then saturated or wrapped to DOUT_WIDTH, selected per transaction.

---
 rtl/train_step_mul_pipe_sat.sv | 119 +++++++++++
 1 files changed

// File: rtl/train_step_mul_pipe_sat.sv
// Multi-lane signed multiplier pipeline for the train_step datapath: full product,
// round-half-up arithmetic right shift, then per-beat saturate or wrap, plus a sticky overflow flag.
module train_step_mul_pipe_sat #(
   parameter int LANES      = 2,
   parameter int DIN0_WIDTH = 8,
   parameter int DIN1_WIDTH = 8,
   parameter int DOUT_WIDTH = 8,
   parameter int SHIFT      = 4,
   parameter int NUM_STAGE  = 2
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        sat_mode,
   input  logic [LANES*DIN0_WIDTH-1:0] din0,
   input  logic [LANES*DIN1_WIDTH-1:0] din1,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DOUT_WIDTH-1:0] dout,
   output logic [LANES-1:0]            ovf_lane,
   output logic                        ovf_sticky,
   input  logic                        clr_ovf
);
   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
   localparam int EW = PW + 1;
   localparam int CW = (EW > DOUT_WIDTH) ? EW : DOUT_WIDTH;
   localparam int DS = NUM_STAGE - 1;
   localparam logic [EW-1:0] RND = (SHIFT > 0) ? (EW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [CW-1:0] MAXV = CW'({1'b0, {(DOUT_WIDTH-1){1'b1}}});
   localparam logic signed [CW-1:0] MINV = ~MAXV;
   localparam logic [DOUT_WIDTH-1:0] MAXD = MAXV[DOUT_WIDTH-1:0];
   localparam logic [DOUT_WIDTH-1:0] MIND = MINV[DOUT_WIDTH-1:0];

   logic                        w_adv;
   logic [LANES*PW-1:0]         w_prod;
   logic [LANES*DOUT_WIDTH-1:0] w_s2_dat;
   logic [LANES-1:0]            w_s2_ovf;

   logic                        r_s1_vld;
   logic                        r_s1_sat;
   logic [LANES*PW-1:0]         r_s1_prod;
   logic [LANES*DOUT_WIDTH-1:0] r_dat [DS];
   logic [LANES-1:0]            r_ovf [DS];
   logic [DS-1:0]               r_vld;
   logic                        r_sticky;

   // Valid/ready: a beat moves on valid&&ready at either port. The whole pipe advances
   // together when the output register is empty or being taken, so in_ready follows out_ready.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [PW-1:0] w_p;
      logic signed [EW-1:0] w_sum;
      logic signed [EW-1:0] w_r;
      logic signed [CW-1:0] w_rc;
      logic                 w_hi;
      logic                 w_lo;

      assign w_prod[l*PW +: PW] = PW'($signed(din0[l*DIN0_WIDTH +: DIN0_WIDTH]))
                                * PW'($signed(din1[l*DIN1_WIDTH +: DIN1_WIDTH]));

      // One extra bit of headroom so adding the rounding half can never wrap.
      assign w_p   = $signed(r_s1_prod[l*PW +: PW]);
      assign w_sum = {w_p[PW-1], w_p} + RND;
      assign w_r   = w_sum >>> SHIFT;
      assign w_rc  = CW'(w_r);
      assign w_hi  = w_rc > MAXV;
      assign w_lo  = w_rc < MINV;

      assign w_s2_ovf[l] = w_hi | w_lo;
      assign w_s2_dat[l*DOUT_WIDTH +: DOUT_WIDTH] = (r_s1_sat && w_hi) ? MAXD :
                                                    (r_s1_sat && w_lo) ? MIND :
                                                    w_rc[DOUT_WIDTH-1:0];
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_sat  <= 1'b0;
         r_s1_prod <= '0;
         r_vld     <= '0;
         for (int s = 0; s < DS; s++) begin
            r_dat[s] <= '0;
            r_ovf[s] <= '0;
         end
      end else if (w_adv) begin
         r_s1_vld  <= in_valid;
         r_s1_sat  <= sat_mode;
         r_s1_prod <= w_prod;
         r_vld[0]  <= r_s1_vld;
         r_dat[0]  <= w_s2_dat;
         r_ovf[0]  <= w_s2_ovf;
         for (int s = 1; s < DS; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_dat[s] <= r_dat[s-1];
            r_ovf[s] <= r_ovf[s-1];
         end
      end
   end

   // Setting wins over clearing so an overflow taken in the clear cycle is not lost.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_sticky <= 1'b0;
      end else if (out_valid && out_ready && (|ovf_lane)) begin
         r_sticky <= 1'b1;
      end else if (clr_ovf) begin
         r_sticky <= 1'b0;
      end
   end

   assign out_valid  = r_vld[DS-1];
   assign dout       = r_dat[DS-1];
   assign ovf_lane   = r_ovf[DS-1];
   assign ovf_sticky = r_sticky;

endmodule
